// File: rtl/pipeline_hazard_unit.sv
// Interlock and forwarding controller for the 5-stage F/D/E/M/W core.
// A shadow pipeline mirrors the destination info of the instructions in E, M and W.
// Each decoding instruction is compared against it in the same cycle, producing
// stall/flush/bubble controls and a registered forward select for the next E stage.
module pipeline_hazard_unit #(
    parameter int NREG       = 16,
    parameter int FWD_EN     = 1,
    parameter int WR_THROUGH = 0,
    parameter int ZERO_REG   = 1,
    parameter int CNT_W      = 16,
    localparam int RW        = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec_valid,
    input  logic [RW-1:0]    dec_rs1,
    input  logic [RW-1:0]    dec_rs2,
    input  logic             dec_use_rs1,
    input  logic             dec_use_rs2,
    input  logic [RW-1:0]    dec_rd,
    input  logic             dec_wre,
    input  logic             dec_is_load,
    input  logic             ex_br_taken,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             bubble_e,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic [CNT_W-1:0] stall_cnt
);

    // Shadow pipeline. Only E needs is_load: a load in M or W already has its data.
    logic          e_valid, e_wre, e_load;
    logic [RW-1:0] e_rd;
    logic          m_valid, m_wre;
    logic [RW-1:0] m_rd;
    logic          w_valid, w_wre;
    logic [RW-1:0] w_rd;

    logic [2:0]    res_a, res_b;
    logic          hazard;
    logic          count_en;

    function automatic logic src_match(input logic v, input logic w,
                                       input logic [RW-1:0] rd,
                                       input logic [RW-1:0] rs,
                                       input logic use_rs);
        logic zero_blk;
        zero_blk = (ZERO_REG != 0) && (rs == '0);
        return v && w && (rd == rs) && use_rs && !zero_blk;
    endfunction

    // Returns {stall_needed, fwd_sel[1:0]}; the nearest producing stage decides.
    function automatic logic [2:0] resolve(input logic [RW-1:0] rs, input logic use_rs,
                                           input logic ev, input logic ew, input logic el,
                                           input logic [RW-1:0] erd,
                                           input logic mv, input logic mw,
                                           input logic [RW-1:0] mrd,
                                           input logic wv, input logic ww,
                                           input logic [RW-1:0] wrd);
        logic [2:0] r;
        r = 3'b000;
        if (src_match(ev, ew, erd, rs, use_rs)) begin
            r = ((FWD_EN != 0) && !el) ? 3'b001 : 3'b100;
        end else if (src_match(mv, mw, mrd, rs, use_rs)) begin
            r = (FWD_EN != 0) ? 3'b010 : 3'b100;
        end else if (src_match(wv, ww, wrd, rs, use_rs)) begin
            r = (WR_THROUGH != 0) ? 3'b000 : 3'b100;
        end
        return r;
    endfunction

    // Hazard decision for the instruction in D; branch flush overrides the stall.
    always_comb begin
        res_a    = resolve(dec_rs1, dec_use_rs1, e_valid, e_wre, e_load, e_rd,
                           m_valid, m_wre, m_rd, w_valid, w_wre, w_rd);
        res_b    = resolve(dec_rs2, dec_use_rs2, e_valid, e_wre, e_load, e_rd,
                           m_valid, m_wre, m_rd, w_valid, w_wre, w_rd);
        hazard   = dec_valid && (res_a[2] || res_b[2]);
        count_en = hazard && !ex_br_taken;
        stall_f  = !reset && count_en;
        stall_d  = !reset && count_en;
        flush_d  = !reset && ex_br_taken;
        bubble_e = !reset && (hazard || ex_br_taken);
    end

    // Advance the shadow pipe, register forward selects and count stall cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_valid   <= 1'b0;
            e_wre     <= 1'b0;
            e_load    <= 1'b0;
            e_rd      <= '0;
            m_valid   <= 1'b0;
            m_wre     <= 1'b0;
            m_rd      <= '0;
            w_valid   <= 1'b0;
            w_wre     <= 1'b0;
            w_rd      <= '0;
            fwd_a_e   <= 2'd0;
            fwd_b_e   <= 2'd0;
            stall_cnt <= '0;
        end else begin
            w_valid <= m_valid;
            w_wre   <= m_wre;
            w_rd    <= m_rd;
            m_valid <= e_valid;
            m_wre   <= e_wre;
            m_rd    <= e_rd;
            if (bubble_e) begin
                e_valid <= 1'b0;
                e_wre   <= 1'b0;
                e_load  <= 1'b0;
                e_rd    <= '0;
                fwd_a_e <= 2'd0;
                fwd_b_e <= 2'd0;
            end else begin
                e_valid <= dec_valid;
                e_wre   <= dec_wre;
                e_load  <= dec_is_load;
                e_rd    <= dec_rd;
                fwd_a_e <= res_a[1:0];
                fwd_b_e <= res_b[1:0];
            end
            if (count_en && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit: three parameter variants share one stimulus stream
// and are each checked every cycle against a stage-list reference model.
module tb_pipeline_hazard_unit;

    logic       clk, reset;
    logic       dec_valid, dec_use_rs1, dec_use_rs2, dec_wre, dec_is_load, ex_br_taken;
    logic [3:0] dec_rs1, dec_rs2, dec_rd;

    logic       sf[3], sd[3], fl[3], bub[3];
    logic [1:0] fa[3], fb[3];
    logic [15:0] cnt0, cnt2;
    logic [7:0]  cnt1;

    int checks   = 0;
    int failures = 0;

    // instance 0: defaults; 1: no forwarding, 8-bit counter; 2: forwarding + write-through, no zero reg
    int P_FWD[3] = '{1, 0, 1};
    int P_WT[3]  = '{0, 0, 1};
    int P_ZR[3]  = '{1, 1, 0};
    int P_MAX[3] = '{65535, 255, 65535};

    pipeline_hazard_unit u_def (
        .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_rd(dec_rd), .dec_wre(dec_wre),
        .dec_is_load(dec_is_load), .ex_br_taken(ex_br_taken), .stall_f(sf[0]), .stall_d(sd[0]),
        .flush_d(fl[0]), .bubble_e(bub[0]), .fwd_a_e(fa[0]), .fwd_b_e(fb[0]), .stall_cnt(cnt0));

    pipeline_hazard_unit #(.FWD_EN(0), .WR_THROUGH(0), .CNT_W(8)) u_nf (
        .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_rd(dec_rd), .dec_wre(dec_wre),
        .dec_is_load(dec_is_load), .ex_br_taken(ex_br_taken), .stall_f(sf[1]), .stall_d(sd[1]),
        .flush_d(fl[1]), .bubble_e(bub[1]), .fwd_a_e(fa[1]), .fwd_b_e(fb[1]), .stall_cnt(cnt1));

    pipeline_hazard_unit #(.FWD_EN(1), .WR_THROUGH(1), .ZERO_REG(0)) u_wt (
        .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_rd(dec_rd), .dec_wre(dec_wre),
        .dec_is_load(dec_is_load), .ex_br_taken(ex_br_taken), .stall_f(sf[2]), .stall_d(sd[2]),
        .flush_d(fl[2]), .bubble_e(bub[2]), .fwd_a_e(fa[2]), .fwd_b_e(fb[2]), .stall_cnt(cnt2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: list of in-flight instructions, index 0 = E, 1 = M, 2 = W
    typedef struct {
        bit v;
        int rd;
        bit w;
        bit ld;
    } sh_t;
    sh_t sh[3][3];
    int  m_fa[3], m_fb[3], m_cnt[3];

    function automatic void model_clear();
        for (int k = 0; k < 3; k++) begin
            for (int s = 0; s < 3; s++) sh[k][s] = '{0, 0, 0, 0};
            m_fa[k] = 0; m_fb[k] = 0; m_cnt[k] = 0;
        end
    endfunction

    // scan stages from nearest to oldest; first producer of rs decides
    function automatic bit src_eval(int k, int rs, bit use_rs, output int fwd);
        fwd = 0;
        if (!use_rs || (P_ZR[k] != 0 && rs == 0)) return 0;
        for (int s = 0; s < 3; s++) begin
            if (sh[k][s].v && sh[k][s].w && sh[k][s].rd == rs) begin
                if (s == 0) begin
                    if (P_FWD[k] != 0 && !sh[k][s].ld) fwd = 1; else return 1;
                end else if (s == 1) begin
                    if (P_FWD[k] != 0) fwd = 2; else return 1;
                end else begin
                    if (P_WT[k] == 0) return 1;
                end
                return 0;
            end
        end
        return 0;
    endfunction

    task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d got=%0d expected=%0d t=%0t", name, k, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_cnt(int k);
        if (k == 0) return {16'd0, cnt0};
        if (k == 1) return {24'd0, cnt1};
        return {16'd0, cnt2};
    endfunction

    // compare all instances with the model at the falling edge, then advance the model
    task automatic step_neg();
        int  f1, f2;
        bit  h1, h2, st;
        int  e_sf, e_fl, e_bub;
        @(negedge clk);
        if (reset) model_clear();
        for (int k = 0; k < 3; k++) begin
            h1 = src_eval(k, int'(dec_rs1), dec_use_rs1, f1);
            h2 = src_eval(k, int'(dec_rs2), dec_use_rs2, f2);
            st = dec_valid && (h1 || h2);
            e_sf  = (!reset && st && !ex_br_taken) ? 1 : 0;
            e_fl  = (!reset && ex_br_taken) ? 1 : 0;
            e_bub = (!reset && (st || ex_br_taken)) ? 1 : 0;
            chk("stall_f", k, 32'(sf[k]), e_sf);
            chk("stall_d", k, 32'(sd[k]), e_sf);
            chk("flush_d", k, 32'(fl[k]), e_fl);
            chk("bubble_e", k, 32'(bub[k]), e_bub);
            chk("fwd_a_e", k, 32'(fa[k]), m_fa[k]);
            chk("fwd_b_e", k, 32'(fb[k]), m_fb[k]);
            chk("stall_cnt", k, dut_cnt(k), m_cnt[k]);
            if (!reset) begin
                sh[k][2] = sh[k][1];
                sh[k][1] = sh[k][0];
                if (e_bub != 0) begin
                    sh[k][0] = '{0, 0, 0, 0};
                    m_fa[k] = 0; m_fb[k] = 0;
                end else begin
                    sh[k][0] = '{dec_valid, int'(dec_rd), dec_wre, dec_is_load};
                    m_fa[k] = f1; m_fb[k] = f2;
                end
                if (st && !ex_br_taken && m_cnt[k] < P_MAX[k]) m_cnt[k]++;
            end
        end
    endtask

    task automatic step_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        step_neg();
        step_pos();
    endtask

    task automatic drive(bit v, int rs1, int rs2, bit u1, bit u2, int rd, bit w, bit ld, bit br);
        dec_valid = v; dec_rs1 = 4'(rs1); dec_rs2 = 4'(rs2);
        dec_use_rs1 = u1; dec_use_rs2 = u2; dec_rd = 4'(rd);
        dec_wre = w; dec_is_load = ld; ex_br_taken = br;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        reset = 1'b0;
    endtask

    typedef struct {
        bit v; int rs1; int rs2; bit u1; bit u2; int rd; bit w; bit ld; bit br;
        int e_sf; int e_fl; int e_bub; int e_fa; int e_fb; int e_cnt;
    } vec_t;
    vec_t tbl[13];

    initial begin
        // forward from E, load-use stall, branch over a hazard, r0 writes
        tbl[0]  = '{1, 1, 2, 1, 1, 3, 1, 0, 0,  0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 3, 5, 1, 1, 4, 1, 0, 0,  0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0};
        tbl[3]  = '{1, 7, 0, 1, 0, 2, 1, 1, 0,  0, 0, 0, 0, 0, 0};
        tbl[4]  = '{1, 1, 2, 1, 1, 6, 1, 0, 0,  1, 0, 1, 0, 0, 0};
        tbl[5]  = '{1, 1, 2, 1, 1, 6, 1, 0, 0,  0, 0, 0, 0, 0, 1};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2, 1};
        tbl[7]  = '{1, 0, 0, 0, 0, 5, 1, 1, 0,  0, 0, 0, 0, 0, 1};
        tbl[8]  = '{1, 5, 0, 1, 0, 7, 1, 0, 1,  0, 1, 1, 0, 0, 1};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1};
        tbl[10] = '{1, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 1};
        tbl[11] = '{1, 0, 0, 1, 1, 8, 1, 0, 0,  0, 0, 0, 0, 0, 1};
        tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1};

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_clear();
        do_reset();

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2,
                  tbl[i].rd, tbl[i].w, tbl[i].ld, tbl[i].br);
            step_neg();
            chk("tbl_stall_f", i, 32'(sf[0]), tbl[i].e_sf);
            chk("tbl_flush_d", i, 32'(fl[0]), tbl[i].e_fl);
            chk("tbl_bubble_e", i, 32'(bub[0]), tbl[i].e_bub);
            chk("tbl_fwd_a_e", i, 32'(fa[0]), tbl[i].e_fa);
            chk("tbl_fwd_b_e", i, 32'(fb[0]), tbl[i].e_fb);
            chk("tbl_stall_cnt", i, 32'(cnt0), tbl[i].e_cnt);
            step_pos();
        end

        // no forwarding: consumer right after producer waits for it to leave W
        do_reset();
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
        cycle();
        drive(1, 3, 0, 1, 0, 4, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step_neg();
            chk("t3_stall", i, 32'(sf[1]), (i < 3) ? 1 : 0);
            step_pos();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step_neg();
        chk("t3_fwd_a", 1, 32'(fa[1]), 0);
        chk("t3_cnt", 1, 32'(cnt1), 3);
        step_pos();

        // reset with loads in flight must forget them
        do_reset();
        drive(1, 0, 0, 0, 0, 9, 1, 1, 0);
        repeat (3) cycle();
        drive(1, 9, 0, 1, 0, 10, 1, 0, 0);
        step_neg();
        chk("t6_pre_stall", 0, 32'(sf[0]), 1);
        step_pos();
        reset = 1'b1;
        step_neg();
        chk("t6_rst_bubble", 0, 32'(bub[0]), 0);
        chk("t6_rst_cnt", 0, 32'(cnt0), 0);
        step_pos();
        reset = 1'b0;
        step_neg();
        chk("t6_stall_def", 0, 32'(sf[0]), 0);
        chk("t6_stall_nf", 1, 32'(sf[1]), 0);
        step_pos();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step_neg();
        chk("t6_fwd_a", 0, 32'(fa[0]), 0);
        step_pos();

        // counter saturation on the 8-bit instance
        do_reset();
        drive(1, 1, 0, 1, 0, 1, 1, 0, 0);
        repeat (400) cycle();
        step_neg();
        chk("sat_cnt", 1, 32'(cnt1), 255);
        step_pos();

        // randomized traffic over a small register window to provoke hazards
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
